// File: rtl/pulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pulse_scheduler
// Purpose  : Round-robin scheduler sharing one pulse-train generator among
//            N_REQ requesters. The granted requester receives a burst of
//            count[i] pulses on 'signal' (high phase H, low phase L cycles),
//            followed by a one-cycle 'done' back to the owner.
// Ports    : clock    - single clock, all logic on posedge
//            reset    - synchronous, active-low
//            req      - per-requester request level
//            count    - per-requester pulse count, field i at [i*CNT_W +: CNT_W]
//            high_len - high-phase length (0 treated as 1), latched at grant
//            low_len  - low-phase length  (0 treated as 1), latched at grant
//            grant    - one-hot owner, held through the DONE cycle
//            done     - one-cycle end-of-burst pulse to the owner
//            signal   - shared pulse output, straight from a flop
//            busy     - high in every state except IDLE
// Options  : PULSE_SCHED_GAP_EN - when defined, every burst is followed by
//            GAP_LEN idle guard cycles (busy=1, grant=0) before re-arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_scheduler #(
    parameter int N_REQ   = 4,
    parameter int CNT_W   = 4,
    parameter int LEN_W   = 4,
    parameter int GAP_LEN = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] count,
    input  logic [LEN_W-1:0]       high_len,
    input  logic [LEN_W-1:0]       low_len,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   signal,
    output logic                   busy
);

    localparam int c_idx_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HIGH = 3'd1,
        S_LOW  = 3'd2,
`ifdef PULSE_SCHED_GAP_EN
        S_DONE = 3'd3,
        S_GAP  = 3'd4
`else
        S_DONE = 3'd3
`endif
    } state_t;

    state_t               r_state, w_state_n;
    logic [c_idx_w-1:0]   r_ptr, w_ptr_n;
    logic [CNT_W-1:0]     r_cnt, w_cnt_n;
    logic [LEN_W-1:0]     r_h, w_h_n;
    logic [LEN_W-1:0]     r_l, w_l_n;
    logic [LEN_W-1:0]     r_phase, w_phase_n;
    logic [N_REQ-1:0]     r_grant, w_grant_n;
    logic [N_REQ-1:0]     r_done, w_done_n;
    logic                 r_signal, w_signal_n;
    logic                 r_busy, w_busy_n;

`ifdef PULSE_SCHED_GAP_EN
    localparam int c_gap_w = (GAP_LEN > 2) ? $clog2(GAP_LEN) : 1;
    logic [c_gap_w-1:0]   r_gap, w_gap_n;
`else
    // GAP_LEN is meaningless without the guard state; keep it referenced.
    logic [31:0]          w_unused_gap;
    assign w_unused_gap = 32'(GAP_LEN);
`endif

    // (base + off) mod N_REQ without a divider; off is always < N_REQ.
    function automatic logic [c_idx_w-1:0] f_wrap(input logic [c_idx_w-1:0] base,
                                                  input int               off);
        logic [c_idx_w:0] s;
        s = {1'b0, base} + (c_idx_w+1)'(off);
        if (s >= (c_idx_w+1)'(N_REQ))
            s = s - (c_idx_w+1)'(N_REQ);
        return s[c_idx_w-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Round-robin pick: walk offsets from the far end back to 0 so the
    // requester closest to the pointer is the last (winning) assignment.
    // ------------------------------------------------------------------
    logic                 w_any;
    logic [c_idx_w-1:0]   w_sel;
    logic [c_idx_w-1:0]   w_cand;
    logic [CNT_W-1:0]     w_k;

    always_comb begin
        w_any  = 1'b0;
        w_sel  = '0;
        w_cand = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            w_cand = f_wrap(r_ptr, off);
            if (req[w_cand]) begin
                w_any = 1'b1;
                w_sel = w_cand;
            end
        end
    end

    always_comb begin
        w_k = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel == c_idx_w'(i))
                w_k = count[i*CNT_W +: CNT_W];
        end
    end

    logic [LEN_W-1:0] w_h_eff, w_l_eff;
    logic [CNT_W-1:0] w_cnt_dec;

    assign w_h_eff   = (high_len == '0) ? LEN_W'(1) : high_len;
    assign w_l_eff   = (low_len  == '0) ? LEN_W'(1) : low_len;
    // Saturating decrement: the pulse counter never wraps below zero.
    assign w_cnt_dec = (r_cnt != '0) ? (r_cnt - CNT_W'(1)) : '0;

    // ------------------------------------------------------------------
    // Next state. Phase counter loads (length-1) and counts down so that a
    // phase of length N occupies exactly N cycles.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_cnt_n   = r_cnt;
        w_h_n     = r_h;
        w_l_n     = r_l;
        w_phase_n = r_phase;
        w_grant_n = r_grant;
`ifdef PULSE_SCHED_GAP_EN
        w_gap_n   = r_gap;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant_n = N_REQ'(1) << w_sel;
                    w_ptr_n   = f_wrap(w_sel, 1);
                    w_cnt_n   = w_k;
                    w_h_n     = w_h_eff;
                    w_l_n     = w_l_eff;
                    w_phase_n = w_h_eff - LEN_W'(1);
                    w_state_n = (w_k != '0) ? S_HIGH : S_DONE;
                end
            end
            S_HIGH: begin
                if (r_phase == '0) begin
                    w_state_n = S_LOW;
                    w_phase_n = r_l - LEN_W'(1);
                end else begin
                    w_phase_n = r_phase - LEN_W'(1);
                end
            end
            S_LOW: begin
                if (r_phase == '0) begin
                    w_cnt_n = w_cnt_dec;
                    if (w_cnt_dec == '0) begin
                        w_state_n = S_DONE;
                    end else begin
                        w_state_n = S_HIGH;
                        w_phase_n = r_h - LEN_W'(1);
                    end
                end else begin
                    w_phase_n = r_phase - LEN_W'(1);
                end
            end
            S_DONE: begin
                w_grant_n = '0;
`ifdef PULSE_SCHED_GAP_EN
                if (GAP_LEN > 0) begin
                    w_state_n = S_GAP;
                    w_gap_n   = c_gap_w'(GAP_LEN - 1);
                end else begin
                    w_state_n = S_IDLE;
                end
`else
                w_state_n = S_IDLE;
`endif
            end
`ifdef PULSE_SCHED_GAP_EN
            S_GAP: begin
                if (r_gap == '0)
                    w_state_n = S_IDLE;
                else
                    w_gap_n = r_gap - c_gap_w'(1);
            end
`endif
            default: begin
                w_state_n = S_IDLE;
                w_grant_n = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so every
    // output (signal in particular) comes straight from a flop.
    assign w_signal_n = (w_state_n == S_HIGH);
    assign w_done_n   = (w_state_n == S_DONE) ? w_grant_n : '0;
    assign w_busy_n   = (w_state_n != S_IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_h      <= '0;
            r_l      <= '0;
            r_phase  <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_signal <= 1'b0;
            r_busy   <= 1'b0;
`ifdef PULSE_SCHED_GAP_EN
            r_gap    <= '0;
`endif
        end else begin
            r_state  <= w_state_n;
            r_ptr    <= w_ptr_n;
            r_cnt    <= w_cnt_n;
            r_h      <= w_h_n;
            r_l      <= w_l_n;
            r_phase  <= w_phase_n;
            r_grant  <= w_grant_n;
            r_done   <= w_done_n;
            r_signal <= w_signal_n;
            r_busy   <= w_busy_n;
`ifdef PULSE_SCHED_GAP_EN
            r_gap    <= w_gap_n;
`endif
        end
    end

    assign grant  = r_grant;
    assign done   = r_done;
    assign signal = r_signal;
    assign busy   = r_busy;

endmodule
`default_nettype wire
